// File: rtl/pipeline_pkg.sv
// pipeline_pkg: opcodes, control encodings and the stage-register control
// bundle shared by the pipeline decoder and the pipeline controller.
package pipeline_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SUB     = 3'b001;
    localparam logic [2:0] ALU_FUNCT   = 3'b010;
    localparam logic [2:0] ALU_PASSIMM = 3'b011;
    localparam logic [2:0] ALU_MUL     = 3'b100;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] PC_PLUS4   = 2'b00;
    localparam logic [1:0] PC_IMM     = 2'b01;
    localparam logic [1:0] PC_RS1IMM  = 2'b10;

    localparam logic [1:0] ALUSRC_RS2 = 2'b00;
    localparam logic [1:0] ALUSRC_IMM = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic [1:0] resultSrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [1:0] ALUSrc;
        logic [2:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Branch condition from the ALU flags; unsupported funct3 is never taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       neg);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT:  taken = neg;
            F3_BGE:  taken = !neg;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/pipeline_decoder.sv
// pipeline_decoder: combinational opcode-to-control-bundle decode for the
// instruction in D. With RV_MUL_EN defined, R-type with funct7b0 set decodes
// as a multiply; otherwise funct7b0 is ignored.
module pipeline_decoder
    import pipeline_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic       funct7b0_i,
    output ctrl_t      ctrl_o,
    output logic [2:0] immSrc_o
);

    logic isMul;

`ifdef RV_MUL_EN
    assign isMul = funct7b0_i;
`else
    assign isMul = 1'b0;
    logic unused_funct7b0;
    assign unused_funct7b0 = funct7b0_i;
`endif

    // Map the opcode to its control bundle; unknown opcodes decode to a bubble.
    always_comb begin
        ctrl_o   = CTRL_BUBBLE;
        immSrc_o = IMM_I;
        case (op_i)
            OP_R: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.ALUOp    = isMul ? ALU_MUL : ALU_FUNCT;
            end
            OP_I: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.ALUSrc   = ALUSRC_IMM;
                ctrl_o.ALUOp    = ALU_FUNCT;
            end
            OP_LOAD: begin
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.ALUSrc    = ALUSRC_IMM;
                ctrl_o.ALUOp     = ALU_ADD;
                ctrl_o.resultSrc = RES_MEM;
            end
            OP_STORE: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.ALUSrc   = ALUSRC_IMM;
                immSrc_o        = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.ALUOp  = ALU_SUB;
                immSrc_o      = IMM_B;
            end
            OP_LUI: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.ALUSrc   = ALUSRC_IMM;
                ctrl_o.ALUOp    = ALU_PASSIMM;
                immSrc_o        = IMM_U;
            end
            OP_JAL: begin
                ctrl_o.jump      = 1'b1;
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.resultSrc = RES_PC4;
                immSrc_o         = IMM_J;
            end
            OP_JALR: begin
                ctrl_o.jalr      = 1'b1;
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.ALUSrc    = ALUSRC_IMM;
                ctrl_o.resultSrc = RES_PC4;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: control and hazard unit for the five-stage pipeline.
// Carries decoded control through the D/E, E/M and M/W stage registers,
// resolves branches in E and generates stall, flush and forwarding selects.
// Optional RV_MUL_EN: multi-cycle multiply in E with a busy down-counter.
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instrD,
    input  logic              zeroE,
    input  logic              negE,
    output logic [2:0]        immSrcD,
    output logic [1:0]        ALUSrcE,
    output logic [2:0]        ALUOpE,
    output logic [2:0]        funct3E,
    output logic              funct7b5E,
    output logic [1:0]        pcSrcE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              memWriteM,
    output logic              regWriteW,
    output logic [1:0]        resultSrcW,
    output logic [REG_AW-1:0] rdW,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE
);

    ctrl_t             ctrlD;
    logic [REG_AW-1:0] rdD, rs1D, rs2D;

    assign rdD  = REG_AW'(instrD[11:7]);
    assign rs1D = REG_AW'(instrD[19:15]);
    assign rs2D = REG_AW'(instrD[24:20]);

    logic unused_instr;
    assign unused_instr = ^{instrD[31], instrD[29:26]};

    pipeline_decoder u_decoder (
        .op_i       (instrD[6:0]),
        .funct7b0_i (instrD[25]),
        .ctrl_o     (ctrlD),
        .immSrc_o   (immSrcD)
    );

    ctrl_t             ctrlE_q, ctrlE_d;
    logic [REG_AW-1:0] rdE_q, rdE_d, rs1E_q, rs1E_d, rs2E_q, rs2E_d;
    logic [2:0]        funct3E_q, funct3E_d;
    logic              funct7b5E_q, funct7b5E_d;

    logic              regWriteM_q, regWriteM_d, memWriteM_q, memWriteM_d;
    logic [1:0]        resultSrcM_q, resultSrcM_d;
    logic [REG_AW-1:0] rdM_q, rdM_d;

    logic              regWriteW_q, regWriteW_d;
    logic [1:0]        resultSrcW_q, resultSrcW_d;
    logic [REG_AW-1:0] rdW_q, rdW_d;

    logic takenE, redirectE, mulBusy, loadUse;

`ifdef RV_MUL_EN
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    logic [CNT_W-1:0] mulCnt_q, mulCnt_d;

    // Remaining busy cycles of the multiply held in E; loads as it enters E.
    always_comb begin
        mulCnt_d = mulCnt_q;
        if (!flushE && !stallE && ctrlD.ALUOp == ALU_MUL) begin
            mulCnt_d = CNT_W'(MUL_LAT - 1);
        end else if (mulCnt_q != '0) begin
            mulCnt_d = mulCnt_q - CNT_W'(1);
        end
    end

    // Multiply busy counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mulCnt_q <= '0;
        end else begin
            mulCnt_q <= mulCnt_d;
        end
    end

    assign mulBusy = (mulCnt_q != '0);
`else
    assign mulBusy = 1'b0;
    logic unused_mul_lat;
    assign unused_mul_lat = (MUL_LAT > 0);
`endif

    // Resolve the PC source from the control held in E.
    always_comb begin
        takenE = ctrlE_q.branch && branch_taken(funct3E_q, zeroE, negE);
        pcSrcE = PC_PLUS4;
        if (ctrlE_q.jalr) begin
            pcSrcE = PC_RS1IMM;
        end else if (ctrlE_q.jump || takenE) begin
            pcSrcE = PC_IMM;
        end
    end

    assign redirectE = (pcSrcE != PC_PLUS4);

    // Operand forwarding; the younger M result wins over W, x0 never forwards.
    always_comb begin
        forwardAE = FWD_RF;
        if (regWriteM_q && rdM_q != '0 && rdM_q == rs1E_q) begin
            forwardAE = FWD_M;
        end else if (regWriteW_q && rdW_q != '0 && rdW_q == rs1E_q) begin
            forwardAE = FWD_W;
        end
        forwardBE = FWD_RF;
        if (regWriteM_q && rdM_q != '0 && rdM_q == rs2E_q) begin
            forwardBE = FWD_M;
        end else if (regWriteW_q && rdW_q != '0 && rdW_q == rs2E_q) begin
            forwardBE = FWD_W;
        end
    end

    // A busy multiply already freezes D, so load-use is only judged once it clears.
    assign loadUse = !mulBusy && ctrlE_q.resultSrc == RES_MEM && rdE_q != '0 &&
                     (rdE_q == rs1D || rdE_q == rs2D);

    assign stallF = (loadUse && !redirectE) || mulBusy;
    assign stallD = stallF;
    assign stallE = mulBusy;
    assign flushD = redirectE;
    assign flushE = redirectE || loadUse;

    // Next stage contents: flush beats stall beats load.
    always_comb begin
        ctrlE_d     = ctrlE_q;
        rdE_d       = rdE_q;
        rs1E_d      = rs1E_q;
        rs2E_d      = rs2E_q;
        funct3E_d   = funct3E_q;
        funct7b5E_d = funct7b5E_q;
        if (flushE) begin
            ctrlE_d     = CTRL_BUBBLE;
            rdE_d       = '0;
            rs1E_d      = '0;
            rs2E_d      = '0;
            funct3E_d   = '0;
            funct7b5E_d = 1'b0;
        end else if (!stallE) begin
            ctrlE_d     = ctrlD;
            rdE_d       = rdD;
            rs1E_d      = rs1D;
            rs2E_d      = rs2D;
            funct3E_d   = instrD[14:12];
            funct7b5E_d = instrD[30];
        end

        regWriteM_d  = 1'b0;
        memWriteM_d  = 1'b0;
        resultSrcM_d = RES_ALU;
        rdM_d        = '0;
        if (!mulBusy) begin
            regWriteM_d  = ctrlE_q.regWrite;
            memWriteM_d  = ctrlE_q.memWrite;
            resultSrcM_d = ctrlE_q.resultSrc;
            rdM_d        = rdE_q;
        end

        regWriteW_d  = regWriteM_q;
        resultSrcW_d = resultSrcM_q;
        rdW_d        = rdM_q;
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrlE_q      <= CTRL_BUBBLE;
            rdE_q        <= '0;
            rs1E_q       <= '0;
            rs2E_q       <= '0;
            funct3E_q    <= '0;
            funct7b5E_q  <= 1'b0;
            regWriteM_q  <= 1'b0;
            memWriteM_q  <= 1'b0;
            resultSrcM_q <= '0;
            rdM_q        <= '0;
            regWriteW_q  <= 1'b0;
            resultSrcW_q <= '0;
            rdW_q        <= '0;
        end else begin
            ctrlE_q      <= ctrlE_d;
            rdE_q        <= rdE_d;
            rs1E_q       <= rs1E_d;
            rs2E_q       <= rs2E_d;
            funct3E_q    <= funct3E_d;
            funct7b5E_q  <= funct7b5E_d;
            regWriteM_q  <= regWriteM_d;
            memWriteM_q  <= memWriteM_d;
            resultSrcM_q <= resultSrcM_d;
            rdM_q        <= rdM_d;
            regWriteW_q  <= regWriteW_d;
            resultSrcW_q <= resultSrcW_d;
            rdW_q        <= rdW_d;
        end
    end

    assign ALUSrcE    = ctrlE_q.ALUSrc;
    assign ALUOpE     = ctrlE_q.ALUOp;
    assign funct3E    = funct3E_q;
    assign funct7b5E  = funct7b5E_q;
    assign memWriteM  = memWriteM_q;
    assign regWriteW  = regWriteW_q;
    assign resultSrcW = resultSrcW_q;
    assign rdW        = rdW_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios plus randomized
// instruction streams checked every cycle against an instruction-level
// model of the pipeline (raw instruction words per stage).
module tb_pipeline_controller;

    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       instrD;
    logic              zeroE, negE;
    logic [2:0]        immSrcD, ALUOpE, funct3E;
    logic [1:0]        ALUSrcE, pcSrcE, forwardAE, forwardBE, resultSrcW;
    logic              funct7b5E, memWriteM, regWriteW;
    logic [REG_AW-1:0] rdW;
    logic              stallF, stallD, stallE, flushD, flushE;

    always #5 clk = ~clk;

    pipeline_controller #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .instrD     (instrD),
        .zeroE      (zeroE),
        .negE       (negE),
        .immSrcD    (immSrcD),
        .ALUSrcE    (ALUSrcE),
        .ALUOpE     (ALUOpE),
        .funct3E    (funct3E),
        .funct7b5E  (funct7b5E),
        .pcSrcE     (pcSrcE),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .memWriteM  (memWriteM),
        .regWriteW  (regWriteW),
        .resultSrcW (resultSrcW),
        .rdW        (rdW),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .flushD     (flushD),
        .flushE     (flushE)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {K_BUB, K_R, K_MUL, K_I, K_LD, K_ST, K_BR, K_LUI, K_JAL, K_JALR} kind_e;

    logic [31:0] wE, wM, wW;
    int          mul_left;
    logic        e_stallD, e_flushD, e_flushE;

    function automatic kind_e kind_of(input logic [31:0] w);
        kind_e k;
        case (w[6:0])
            7'h33: begin
                k = K_R;
`ifdef RV_MUL_EN
                if (w[25]) k = K_MUL;
`endif
            end
            7'h13:   k = K_I;
            7'h03:   k = K_LD;
            7'h23:   k = K_ST;
            7'h63:   k = K_BR;
            7'h37:   k = K_LUI;
            7'h6F:   k = K_JAL;
            7'h67:   k = K_JALR;
            default: k = K_BUB;
        endcase
        return k;
    endfunction

    function automatic logic writes_rd(input kind_e k);
        return (k == K_R || k == K_MUL || k == K_I || k == K_LD ||
                k == K_LUI || k == K_JAL || k == K_JALR);
    endfunction

    function automatic logic [1:0] res_src(input kind_e k);
        if (k == K_LD) return 2'd1;
        if (k == K_JAL || k == K_JALR) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] alu_src(input kind_e k);
        return (k == K_I || k == K_LD || k == K_ST || k == K_LUI || k == K_JALR) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] alu_op(input kind_e k);
        if (k == K_R || k == K_I) return 3'd2;
        if (k == K_BR)  return 3'd1;
        if (k == K_LUI) return 3'd3;
        if (k == K_MUL) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [2:0] imm_src(input kind_e k);
        if (k == K_ST)  return 3'd1;
        if (k == K_BR)  return 3'd2;
        if (k == K_LUI) return 3'd3;
        if (k == K_JAL) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (writes_rd(kind_of(wM)) && wM[11:7] != 5'd0 && wM[11:7] == rs) return 2'b10;
        if (writes_rd(kind_of(wW)) && wW[11:7] != 5'd0 && wW[11:7] == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_all();
        kind_e      kE, kM, kW;
        logic       taken, busy, lu, redir;
        logic [1:0] pc;
        logic [4:0] rdE;
        kE = kind_of(wE);
        kM = kind_of(wM);
        kW = kind_of(wW);
        case (wE[14:12])
            3'd0:    taken = zeroE;
            3'd1:    taken = !zeroE;
            3'd4:    taken = negE;
            3'd5:    taken = !negE;
            default: taken = 1'b0;
        endcase
        if (kE == K_JALR) pc = 2'd2;
        else if (kE == K_JAL || (kE == K_BR && taken)) pc = 2'd1;
        else pc = 2'd0;
        busy  = (mul_left > 0);
        redir = (pc != 2'd0);
        rdE   = wE[11:7];
        lu    = !busy && kE == K_LD && rdE != 5'd0 &&
                (rdE == instrD[19:15] || rdE == instrD[24:20]);
        e_stallD = (lu && !redir) || busy;
        e_flushD = redir;
        e_flushE = redir || lu;

        check_val("immSrcD",    immSrcD,    imm_src(kind_of(instrD)));
        check_val("ALUSrcE",    ALUSrcE,    alu_src(kE));
        check_val("ALUOpE",     ALUOpE,     alu_op(kE));
        check_val("funct3E",    funct3E,    wE[14:12]);
        check_val("funct7b5E",  funct7b5E,  wE[30]);
        check_val("pcSrcE",     pcSrcE,     pc);
        check_val("forwardAE",  forwardAE,  fwd_exp(wE[19:15]));
        check_val("forwardBE",  forwardBE,  fwd_exp(wE[24:20]));
        check_val("memWriteM",  memWriteM,  kM == K_ST);
        check_val("regWriteW",  regWriteW,  writes_rd(kW));
        check_val("resultSrcW", resultSrcW, res_src(kW));
        check_val("rdW",        rdW,        wW[11:7]);
        check_val("stallF",     stallF,     e_stallD);
        check_val("stallD",     stallD,     e_stallD);
        check_val("stallE",     stallE,     busy);
        check_val("flushD",     flushD,     e_flushD);
        check_val("flushE",     flushE,     e_flushE);
    endtask

    task automatic model_advance();
        if (!rst) begin
            wE = '0; wM = '0; wW = '0; mul_left = 0;
        end else begin
            wW = wM;
            if (mul_left > 0) begin
                wM = '0;
                mul_left--;
            end else begin
                wM = wE;
                if (e_flushE) begin
                    wE = '0;
                end else begin
                    wE = instrD;
                    if (kind_of(instrD) == K_MUL) mul_left = MUL_LAT - 1;
                end
            end
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic z, input logic n, input logic r);
        @(negedge clk);
        instrD = ins; zeroE = z; negE = n; rst = r;
        #1;
        check_all();
        model_advance();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        int          sel;
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        imm = 12'($urandom);
        f3  = 3'($urandom);
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'h01;
        endcase
        sel = $urandom_range(0, 10);
        case (sel)
            0, 1:    w = {f7, rs2, rs1, f3, rd, 7'h33};
            2:       w = {imm, rs1, f3, rd, 7'h13};
            3, 4:    w = {imm, rs1, 3'b010, rd, 7'h03};
            5:       w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
            6:       w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h63};
            7:       w = {imm, 8'($urandom), rd, 7'h37};
            8:       w = {imm, 8'($urandom), rd, 7'h6F};
            9:       w = {imm, rs1, 3'b000, rd, 7'h67};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    localparam logic [31:0] ADD_X3  = 32'h002081B3;
    localparam logic [31:0] ADD_X5  = 32'h002082B3;
    localparam logic [31:0] SUB_X6  = 32'h40128333;
    localparam logic [31:0] ADDI_11 = 32'h00100593;
    localparam logic [31:0] LW_X7   = 32'h0000A383;
    localparam logic [31:0] ADD_X8  = 32'h00238433;
    localparam logic [31:0] BEQ     = 32'h00208063;
    localparam logic [31:0] JALR    = 32'h000100E7;
    localparam logic [31:0] MUL_X9  = 32'h022084B3;

    initial begin
        logic [31:0] cur;
        rst = 1'b0; instrD = '0; zeroE = 1'b0; negE = 1'b0;
        wE = '0; wM = '0; wW = '0; mul_left = 0;
        e_stallD = 1'b0; e_flushD = 1'b0; e_flushE = 1'b0;
        repeat (2) @(posedge clk);

        // reset state with a bubble in D
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("reset_regWriteW", regWriteW, 0);
        check_val("reset_stallF", stallF, 0);

        // add x3 reaches W three edges after entry
        step(ADD_X3, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("add_early_regWriteW", regWriteW, 0);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("add_regWriteW", regWriteW, 1);
        check_val("add_rdW", rdW, 3);
        check_val("add_resultSrcW", resultSrcW, 0);

        // back-to-back dependency forwards from M
        step(ADD_X5, 1'b0, 1'b0, 1'b1);
        step(SUB_X6, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("fwd_m", forwardAE, 2);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("fwd_m_gone", forwardAE, 0);

        // one independent instruction between: forward from W
        step(ADD_X5, 1'b0, 1'b0, 1'b1);
        step(ADDI_11, 1'b0, 1'b0, 1'b1);
        step(SUB_X6, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("fwd_w", forwardAE, 1);
        step(32'h0, 1'b0, 1'b0, 1'b1);

        // load-use: one stall cycle, then forward from W
        step(LW_X7, 1'b0, 1'b0, 1'b1);
        step(ADD_X8, 1'b0, 1'b0, 1'b1);
        check_val("lu_stallF", stallF, 1);
        check_val("lu_stallD", stallD, 1);
        check_val("lu_flushE", flushE, 1);
        step(ADD_X8, 1'b0, 1'b0, 1'b1);
        check_val("lu_release_stallF", stallF, 0);
        check_val("lu_release_flushE", flushE, 0);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("lu_fwd_w", forwardAE, 1);
        step(32'h0, 1'b0, 1'b0, 1'b1);

        // branches and jalr
        step(BEQ, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b1, 1'b0, 1'b1);
        check_val("beq_taken_pcSrc", pcSrcE, 1);
        check_val("beq_taken_flushD", flushD, 1);
        check_val("beq_taken_flushE", flushE, 1);
        step(BEQ, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("beq_not_pcSrc", pcSrcE, 0);
        check_val("beq_not_flushD", flushD, 0);
        step(JALR, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("jalr_pcSrc", pcSrcE, 2);
        check_val("jalr_flushD", flushD, 1);
        step(32'h0, 1'b0, 1'b0, 1'b1);

`ifdef RV_MUL_EN
        begin
            int stall_cnt;
            int w_at;
            stall_cnt = 0;
            w_at = -1;
            step(MUL_X9, 1'b0, 1'b0, 1'b1);
            for (int i = 1; i <= 8; i++) begin
                step(32'h0, 1'b0, 1'b0, 1'b1);
                if (stallE === 1'b1) stall_cnt++;
                if (w_at < 0 && regWriteW === 1'b1 && rdW === 5'd9) w_at = i;
            end
            check_val("mul_stall_cycles", stall_cnt, MUL_LAT - 1);
            check_val("mul_w_arrival", w_at, 3 + MUL_LAT - 1);
        end
        step(MUL_X9, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("mul_busy_stallE", stallE, 1);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("mul_rst_stallE", stallE, 0);
        check_val("mul_rst_stallF", stallF, 0);
        check_val("mul_rst_stallD", stallD, 0);
`else
        step(MUL_X9, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        check_val("mul_as_add_ALUOp", ALUOpE, 2);
        check_val("mul_as_add_stallE", stallE, 0);
`endif

        // randomized stream; D is held on stall and bubbled on flush
        cur = rand_instr();
        for (int c = 0; c < 600; c++) begin
            logic r;
            r = ($urandom_range(0, 79) != 0);
            step(cur, 1'($urandom), 1'($urandom), r);
            if (!r || e_flushD) cur = '0;
            else if (!e_stallD) cur = rand_instr();
            if (cur == '0 && $urandom_range(0, 1) == 0) cur = rand_instr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
